keypad_calc_core: RTL and testbench



---
 rtl/calc_pkg.sv | 43 ++++
 rtl/key_event_detect.sv | 60 ++++++
 rtl/keypad_calc_core.sv | 177 +++++++++++++++++
 tb/tb_keypad_calc_core.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types for the keypad calculator: FSM states, operator key codes
// and the scanner-code to decimal-digit map.
package calc_pkg;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        RESULT  = 2'd2,
        ERROR   = 2'd3
    } state_t;

    localparam logic [4:0] KEY_PLUS  = 5'd3;
    localparam logic [4:0] KEY_MINUS = 5'd11;
    localparam logic [4:0] KEY_EQ    = 5'd7;
    localparam logic [4:0] KEY_CLR   = 5'd12;

    typedef struct packed {
        logic       valid;
        logic [3:0] digit;
    } digit_t;

    // The keypad matrix is not laid out in numeric order.
    function automatic digit_t key_to_digit(input logic [4:0] code);
        digit_t d;
        d.valid = 1'b1;
        d.digit = 4'd0;
        case (code)
            5'd0:    d.digit = 4'd1;
            5'd1:    d.digit = 4'd2;
            5'd2:    d.digit = 4'd3;
            5'd4:    d.digit = 4'd4;
            5'd5:    d.digit = 4'd5;
            5'd6:    d.digit = 4'd6;
            5'd8:    d.digit = 4'd7;
            5'd9:    d.digit = 4'd8;
            5'd10:   d.digit = 4'd9;
            5'd13:   d.digit = 4'd0;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/key_event_detect.sv
// Samples the scanner on a divided tick and emits one registered event per
// key release, carrying the last code seen while the key was held.
module key_event_detect #(
    parameter int DIV_LOG2 = 10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       key_flag_i,
    input  logic [4:0] key_code_i,
    output logic       ev_valid_o,
    output logic [4:0] ev_code_o
);

    logic       tick;
    logic       prev_flag_q;
    logic [4:0] code_q;
    logic       ev_valid_q;
    logic [4:0] ev_code_q;

    generate
        if (DIV_LOG2 == 0) begin : g_no_div
            assign tick = 1'b1;
        end else begin : g_div
            logic [DIV_LOG2-1:0] div_q;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    div_q <= '0;
                end else begin
                    div_q <= div_q + DIV_LOG2'(1);
                end
            end
            assign tick = &div_q;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_flag_q <= 1'b0;
            code_q      <= '0;
            ev_valid_q  <= 1'b0;
            ev_code_q   <= '0;
        end else begin
            ev_valid_q <= 1'b0;
            if (tick) begin
                prev_flag_q <= key_flag_i;
                if (key_flag_i) begin
                    code_q <= key_code_i;
                end
                if (!key_flag_i && prev_flag_q) begin
                    ev_valid_q <= 1'b1;
                    ev_code_q  <= code_q;
                end
            end
        end
    end

    assign ev_valid_o = ev_valid_q;
    assign ev_code_o  = ev_code_q;

endmodule

// File: rtl/keypad_calc_core.sv
// Keypad calculator: multi-digit entry, add/subtract with sign, result
// chaining and a sticky error state left only by the clear key.
//
// state   | meaning
// ENTER_A | typing first operand
// ENTER_B | operator latched, typing second operand
// RESULT  | showing result magnitude and sign
// ERROR   | chained result out of range; wait for clear
module keypad_calc_core
    import calc_pkg::*;
#(
    parameter int W        = 10,
    parameter int DIGITS   = 3,
    parameter int DIV_LOG2 = 10
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         key_flag,
    input  logic [4:0]   key_code,
    output logic [W:0]   value,
    output logic         neg,
    output logic         err,
    output logic [1:0]   state_o,
    output logic         result_valid
);

    localparam int NW = $clog2(DIGITS + 1);

    logic       ev_valid;
    logic [4:0] ev_code;

    key_event_detect #(.DIV_LOG2(DIV_LOG2)) u_key_event_detect (
        .clk_i      (clk_in),
        .rst_i      (rst),
        .key_flag_i (key_flag),
        .key_code_i (key_code),
        .ev_valid_o (ev_valid),
        .ev_code_o  (ev_code)
    );

    state_t        state_q, state_d;
    logic [W-1:0]  entry_q, entry_d;
    logic [NW-1:0] ndig_q,  ndig_d;
    logic [W-1:0]  a_q,     a_d;
    logic          sub_q,   sub_d;
    logic [W:0]    r_q,     r_d;
    logic          neg_q,   neg_d;
    logic          rv_q,    rv_d;

    digit_t kd;
    logic   is_op;
    logic   op_sub;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= ENTER_A;
            entry_q <= '0;
            ndig_q  <= '0;
            a_q     <= '0;
            sub_q   <= 1'b0;
            r_q     <= '0;
            neg_q   <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            ndig_q  <= ndig_d;
            a_q     <= a_d;
            sub_q   <= sub_d;
            r_q     <= r_d;
            neg_q   <= neg_d;
            rv_q    <= rv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        ndig_d  = ndig_q;
        a_d     = a_q;
        sub_d   = sub_q;
        r_d     = r_q;
        neg_d   = neg_q;
        rv_d    = 1'b0;
        kd      = key_to_digit(ev_code);
        is_op   = (ev_code == KEY_PLUS) || (ev_code == KEY_MINUS);
        op_sub  = (ev_code == KEY_MINUS);

        if (ev_valid) begin
            if (ev_code == KEY_CLR) begin
                state_d = ENTER_A;
                entry_d = '0;
                ndig_d  = '0;
                a_d     = '0;
                sub_d   = 1'b0;
                r_d     = '0;
                neg_d   = 1'b0;
            end else begin
                case (state_q)
                    ENTER_A, ENTER_B: begin
                        if (kd.valid) begin
                            // A full entry ignores further digits rather than wrapping.
                            if (ndig_q < NW'(DIGITS)) begin
                                entry_d = entry_q * W'(10) + W'(kd.digit);
                                ndig_d  = ndig_q + 1'b1;
                            end
                        end else if (is_op) begin
                            sub_d = op_sub;
                            if (state_q == ENTER_A) begin
                                a_d     = entry_q;
                                entry_d = '0;
                                ndig_d  = '0;
                                state_d = ENTER_B;
                            end
                        end else if (ev_code == KEY_EQ && state_q == ENTER_B) begin
                            if (!sub_q) begin
                                r_d   = {1'b0, a_q} + {1'b0, entry_q};
                                neg_d = 1'b0;
                            end else if (a_q >= entry_q) begin
                                r_d   = {1'b0, a_q - entry_q};
                                neg_d = 1'b0;
                            end else begin
                                r_d   = {1'b0, entry_q - a_q};
                                neg_d = 1'b1;
                            end
                            rv_d    = 1'b1;
                            entry_d = '0;
                            ndig_d  = '0;
                            state_d = RESULT;
                        end
                    end
                    RESULT: begin
                        if (kd.valid) begin
                            a_d     = '0;
                            entry_d = W'(kd.digit);
                            ndig_d  = NW'(1);
                            neg_d   = 1'b0;
                            state_d = ENTER_A;
                        end else if (is_op) begin
                            // Only a non-negative result that fits in W bits can seed the next operand.
                            if (!neg_q && !r_q[W]) begin
                                a_d     = r_q[W-1:0];
                                sub_d   = op_sub;
                                entry_d = '0;
                                ndig_d  = '0;
                                state_d = ENTER_B;
                            end else begin
                                state_d = ERROR;
                            end
                        end
                    end
                    ERROR: begin
                        state_d = ERROR;
                    end
                    default: begin
                        state_d = ENTER_A;
                    end
                endcase
            end
        end
    end

    always_comb begin
        value = '0;
        case (state_q)
            ENTER_A, ENTER_B: value = {1'b0, entry_q};
            RESULT:           value = r_q;
            default:          value = '0;
        endcase
    end

    assign neg          = neg_q;
    assign err          = (state_q == ERROR);
    assign state_o      = state_q;
    assign result_valid = rv_q;

endmodule

// File: tb/tb_keypad_calc_core.sv
// Directed bench for keypad_calc_core with sampling every cycle; expected
// values are hand-computed from the key sequences.
module tb_keypad_calc_core;

    localparam int W = 10;

    logic         clk_in = 1'b0;
    logic         rst;
    logic         key_flag;
    logic [4:0]   key_code;
    logic [W:0]   value;
    logic         neg;
    logic         err;
    logic [1:0]   state_o;
    logic         result_valid;

    int n_cmp = 0;
    int n_bad = 0;
    int rv_cnt = 0;

    localparam logic [1:0] S_A = 2'd0, S_B = 2'd1, S_R = 2'd2, S_E = 2'd3;
    localparam logic [4:0] K_PLUS = 5'd3, K_MINUS = 5'd11, K_EQ = 5'd7, K_CLR = 5'd12;

    keypad_calc_core #(.W(W), .DIGITS(3), .DIV_LOG2(0)) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .key_flag     (key_flag),
        .key_code     (key_code),
        .value        (value),
        .neg          (neg),
        .err          (err),
        .state_o      (state_o),
        .result_valid (result_valid)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (result_valid === 1'b1) rv_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] dcode(input int d);
        case (d)
            1: return 5'd0;
            2: return 5'd1;
            3: return 5'd2;
            4: return 5'd4;
            5: return 5'd5;
            6: return 5'd6;
            7: return 5'd8;
            8: return 5'd9;
            9: return 5'd10;
            default: return 5'd13;
        endcase
    endfunction

    task automatic press(input logic [4:0] c);
        key_flag = 1'b1;
        key_code = c;
        cycles(2);
        key_flag = 1'b0;
        cycles(3);
    endtask

    task automatic digit(input int d);
        press(dcode(d));
    endtask

    initial begin
        rst = 1'b1;
        key_flag = 1'b0;
        key_code = 5'd0;
        cycles(3);
        rst = 1'b0;
        cycles(1);
        chk("reset_state", state_o, S_A);
        chk("reset_value", value, 0);
        chk("reset_neg", neg, 0);
        chk("reset_err", err, 0);
        chk("reset_rv", result_valid, 0);

        // 12 + 34 = 46
        digit(1);
        chk("entry_1", value, 1);
        digit(2);
        chk("entry_12", value, 12);
        press(K_PLUS);
        chk("op_state_b", state_o, S_B);
        chk("op_value_0", value, 0);
        digit(3);
        digit(4);
        chk("entry_34", value, 34);
        press(K_EQ);
        chk("add_value", value, 46);
        chk("add_neg", neg, 0);
        chk("add_state", state_o, S_R);
        chk("add_rv_cnt", rv_cnt, 1);

        // 5 - 9 = -4
        digit(5);
        chk("result_digit_state", state_o, S_A);
        chk("result_digit_value", value, 5);
        press(K_MINUS);
        digit(9);
        press(K_EQ);
        chk("sub_value", value, 4);
        chk("sub_neg", neg, 1);
        chk("sub_rv_cnt", rv_cnt, 2);

        // fourth digit is dropped
        digit(9);
        chk("digit_after_neg_clears_neg", neg, 0);
        digit(9);
        digit(9);
        digit(9);
        chk("entry_limit_999", value, 999);

        // 999 + 999 = 1998, chaining it overflows W bits
        press(K_PLUS);
        digit(9);
        digit(9);
        digit(9);
        press(K_EQ);
        chk("add_1998", value, 1998);
        chk("add_1998_state", state_o, S_R);
        press(K_PLUS);
        chk("overflow_state", state_o, S_E);
        chk("overflow_err", err, 1);
        chk("overflow_value", value, 0);
        digit(4);
        press(K_EQ);
        chk("error_sticky", state_o, S_E);
        press(K_CLR);
        chk("clear_state", state_o, S_A);
        chk("clear_value", value, 0);
        chk("clear_err", err, 0);

        // 7 + 3 = 10, then chain - 2 = 8
        digit(7);
        press(K_PLUS);
        digit(3);
        press(K_EQ);
        chk("chain_first", value, 10);
        press(K_MINUS);
        chk("chain_state_b", state_o, S_B);
        chk("chain_value_0", value, 0);
        digit(2);
        press(K_EQ);
        chk("chain_value", value, 8);
        chk("chain_neg", neg, 0);
        chk("chain_rv_cnt", rv_cnt, 5);

        // '=' in ENTER_B with op replaced: 5 + (-) 5 = 0
        press(K_CLR);
        digit(5);
        press(K_EQ);
        chk("eq_ignored_in_a", state_o, S_A);
        press(5'd14);
        chk("code14_ignored", value, 5);
        press(K_PLUS);
        press(K_MINUS);
        chk("op_replace_value", value, 0);
        digit(5);
        press(K_EQ);
        chk("equal_sub_value", value, 0);
        chk("equal_sub_neg", neg, 0);

        // reset during ENTER_B with entry 12
        press(K_CLR);
        press(K_PLUS);
        digit(1);
        digit(2);
        chk("pre_rst_state", state_o, S_B);
        chk("pre_rst_value", value, 12);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        chk("mid_rst_state", state_o, S_A);
        chk("mid_rst_value", value, 0);

        // key held for 50 ticks produces exactly one digit
        cycles(2);
        key_flag = 1'b1;
        key_code = dcode(5);
        cycles(50);
        key_flag = 1'b0;
        cycles(5);
        chk("held_key_value", value, 5);
        chk("held_key_state", state_o, S_A);
        chk("total_rv_cnt", rv_cnt, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
